// File: rtl/uart_tx_scheduler_pkg.sv
// rtl/uart_tx_scheduler_pkg.sv - shared types and constants for the UART TX scheduler
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } sched_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and UART_TX side signals of the scheduler
interface uart_tx_scheduler_if
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_par_en;
   logic [NUM_REQ-1:0]            req_par_typ;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         P_DATA;
   logic                          PAR_EN;
   logic                          PAR_TYP;
   logic                          DATA_VALID;
   logic                          Busy;

   // scheduler side
   modport master (
      input  req_valid, req_data, req_par_en, req_par_typ, Busy,
      output req_ready, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
   );

   // requesters plus UART_TX side
   modport slave (
      output req_valid, req_data, req_par_en, req_par_typ, Busy,
      input  req_ready, P_DATA, PAR_EN, PAR_TYP, DATA_VALID
   );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
   parameter int N = 2,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   // first requester found searching upward from the slot after the last winner
   always_comb begin
      int p;
      p     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         p = (int'(ptr) + k) % N;
         if (!any && req[p]) begin
            any      = 1'b1;
            grant[p] = 1'b1;
            idx      = W'(p);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART_TX between requesters
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int BUSY_WAIT  = 4,
   localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_scheduler_if.master  bus,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 timeout_err
);

   localparam logic [3:0] WAIT_LIM = 4'(BUSY_WAIT);

   sched_state_t        state, state_nxt;
   logic [IDX_W-1:0]    rr_ptr;
   logic [3:0]          wait_cnt;
   logic [NUM_REQ-1:0]  arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic                arb_any;
   logic                take;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // the last winner doubles as the round-robin pointer
   assign grant_id = rr_ptr;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state, handshake, launch strobe and timeout pulse
   always_comb begin
      state_nxt      = state;
      take           = 1'b0;
      bus.req_ready  = '0;
      bus.DATA_VALID = 1'b0;
      timeout_err    = 1'b0;
      case (state)
         IDLE: begin
            // a foreign frame in flight blocks any new grant
            if (!bus.Busy && arb_any) begin
               bus.req_ready = arb_grant;
               take          = 1'b1;
               state_nxt     = LAUNCH;
            end
         end
         LAUNCH: begin
            bus.DATA_VALID = 1'b1;
            state_nxt      = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (bus.Busy) begin
               state_nxt = WAIT_DONE;
            end else if (wait_cnt == WAIT_LIM) begin
               // UART_TX never picked the byte up; drop it
               timeout_err = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!bus.Busy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cycles spent waiting for Busy after the launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state == LAUNCH) begin
         wait_cnt <= '0;
      end else if (state == WAIT_BUSY && !bus.Busy && wait_cnt != WAIT_LIM) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // latch the winner's byte and parity setup on the handshake edge only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.P_DATA  <= '0;
         bus.PAR_EN  <= 1'b0;
         bus.PAR_TYP <= PAR_EVEN;
         rr_ptr      <= IDX_W'(NUM_REQ - 1);
      end else if (take) begin
         bus.P_DATA  <= bus.req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
         bus.PAR_EN  <= bus.req_par_en[arb_idx];
         bus.PAR_TYP <= bus.req_par_typ[arb_idx];
         rr_ptr      <= arb_idx;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
   import uart_tx_sched_pkg::*;

   localparam int NR = 2;
   localparam int DW = 8;
   localparam int BW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [0:0] grant_id;
   logic       timeout_err;

   logic model_on;
   logic busy_model;
   logic busy_manual;
   int   frame_len = 11;

   int checks   = 0;
   int failures = 0;

   uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

   uart_tx_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_WAIT(BW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   assign bus.Busy = model_on ? busy_model : busy_manual;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] pe, input logic [1:0] pt);
      bus.req_valid   = v;
      bus.req_data    = {d1, d0};
      bus.req_par_en  = pe;
      bus.req_par_typ = pt;
   endtask

   // UART_TX stand-in: Busy rises in the launch cycle and holds for frame_len cycles
   initial begin
      busy_model = 1'b0;
      forever begin
         @(negedge clk);
         if (model_on && bus.DATA_VALID === 1'b1) begin
            busy_model = 1'b1;
            repeat (frame_len) @(negedge clk);
            busy_model = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int dv_cnt;
      logic prev_dv;

      reset = 1'b0; model_on = 1'b1; busy_manual = 1'b0;
      set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      repeat (3) @(negedge clk);
      check("rst_ready",  bus.req_ready, 2'b00);
      check("rst_dv",     bus.DATA_VALID, 1'b0);
      check("rst_pdata",  bus.P_DATA, 8'h00);
      check("rst_paren",  bus.PAR_EN, 1'b0);
      check("rst_partyp", bus.PAR_TYP, 1'b0);
      check("rst_gid",    grant_id, 1'b1);
      check("rst_tmo",    timeout_err, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      // single requester 1
      set_req(2'b10, 8'h00, 8'hA5, 2'b10, 2'b10);
      #1 check("t1_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      @(negedge clk);
      check("t1_dv",     bus.DATA_VALID, 1'b1);
      check("t1_pdata",  bus.P_DATA, 8'hA5);
      check("t1_paren",  bus.PAR_EN, 1'b1);
      check("t1_partyp", bus.PAR_TYP, 1'b1);
      check("t1_gid",    grant_id, 1'b1);
      check("t1_ready0", bus.req_ready, 2'b00);
      @(negedge clk);
      check("t1_dv_once", bus.DATA_VALID, 1'b0);
      repeat (30) @(negedge clk);

      // both valid continuously: alternate 0,1,0,1
      set_req(2'b11, 8'h11, 8'h22, 2'b00, 2'b00);
      n = 0; prev_dv = 1'b0;
      for (int c = 0; c < 300 && n < 4; c++) begin
         @(negedge clk);
         if (bus.DATA_VALID === 1'b1) begin
            check($sformatf("t2_gid%0d", n), grant_id, n % 2);
            check($sformatf("t2_pdata%0d", n), bus.P_DATA, (n % 2) ? 8'h22 : 8'h11);
            check($sformatf("t2_single%0d", n), prev_dv, 1'b0);
            n++;
            if (n == 4) set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
         end
         prev_dv = bus.DATA_VALID;
      end
      check("t2_grants", n, 4);
      set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      repeat (30) @(negedge clk);

      // Busy never rises: timeout BW+1 cycles after launch
      model_on = 1'b0;
      set_req(2'b01, 8'h3C, 8'h00, 2'b00, 2'b00);
      #1 check("t3_ready", bus.req_ready, 2'b01);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      @(negedge clk);
      check("t3_dv",    bus.DATA_VALID, 1'b1);
      check("t3_pdata", bus.P_DATA, 8'h3C);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("t3_tmo%0d", k), timeout_err, (k == 5) ? 1'b1 : 1'b0);
      end
      set_req(2'b10, 8'h00, 8'h5A, 2'b00, 2'b00);
      #1 check("t3_next_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      @(negedge clk);
      check("t3_next_dv",    bus.DATA_VALID, 1'b1);
      check("t3_next_pdata", bus.P_DATA, 8'h5A);
      check("t3_next_gid",   grant_id, 1'b1);
      repeat (10) @(negedge clk);

      // foreign Busy blocks the grant
      busy_manual = 1'b1;
      set_req(2'b01, 8'h77, 8'h00, 2'b00, 2'b00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("t4_hold%0d", k), bus.req_ready, 2'b00);
      end
      busy_manual = 1'b0;
      #1 check("t4_ready", bus.req_ready, 2'b01);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      @(negedge clk);
      check("t4_dv",    bus.DATA_VALID, 1'b1);
      check("t4_pdata", bus.P_DATA, 8'h77);
      check("t4_gid",   grant_id, 1'b0);
      repeat (10) @(negedge clk);

      // reset during WAIT_DONE
      model_on = 1'b1;
      set_req(2'b10, 8'h00, 8'h99, 2'b10, 2'b00);
      #1 check("t5_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      repeat (3) @(negedge clk);
      check("t5_pdata_pre", bus.P_DATA, 8'h99);
      reset = 1'b0;
      #1;
      check("t5_pdata",  bus.P_DATA, 8'h00);
      check("t5_paren",  bus.PAR_EN, 1'b0);
      check("t5_partyp", bus.PAR_TYP, 1'b0);
      check("t5_dv",     bus.DATA_VALID, 1'b0);
      check("t5_gid",    grant_id, 1'b1);
      check("t5_ready0", bus.req_ready, 2'b00);
      check("t5_tmo",    timeout_err, 1'b0);
      model_on = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      set_req(2'b11, 8'hC3, 8'h3C, 2'b01, 2'b00);
      #1 check("t5_post_ready", bus.req_ready, 2'b01);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      @(negedge clk);
      check("t5_post_dv",    bus.DATA_VALID, 1'b1);
      check("t5_post_gid",   grant_id, 1'b0);
      check("t5_post_pdata", bus.P_DATA, 8'hC3);
      check("t5_post_paren", bus.PAR_EN, 1'b1);
      repeat (10) @(negedge clk);

      // one-cycle valid pulse during WAIT_DONE is ignored
      model_on = 1'b1;
      set_req(2'b10, 8'h00, 8'hE7, 2'b00, 2'b00);
      #1 check("t6_ready", bus.req_ready, 2'b10);
      @(posedge clk); #1 set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      repeat (3) @(negedge clk);
      set_req(2'b01, 8'h00, 8'h00, 2'b00, 2'b00);
      #1 check("t6_pulse_ready", bus.req_ready, 2'b00);
      @(negedge clk);
      set_req(2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
      dv_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.DATA_VALID === 1'b1) dv_cnt++;
      end
      check("t6_no_dv", dv_cnt, 0);
      check("t6_pdata", bus.P_DATA, 8'hE7);
      check("t6_gid",   grant_id, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
